// File: rtl/des_iter_engine_pkg.sv
// DES constant tables and the permutation / S-box / key-rotation helpers.
// Vectors are [0:N-1] with bit 0 = DES bit 1, so tables index directly (entry-1).
package des_iter_engine_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam int IP_T [64] = '{
    58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
    57,49,41,33,25,17, 9,1, 59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{
    40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31, 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
    36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27, 34,2,42,10,50,18,58,26, 33,1,41, 9,49,17,57,25};
  localparam int E_T [48] = '{
    32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9,10,11,12,13,12,13,14,15,16,17,
    16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32, 1};
  localparam int P_T [32] = '{
    16, 7,20,21,29,12,28,17, 1,15,23,26, 5,18,31,10, 2, 8,24,14,32,27, 3, 9,19,13,30, 6,22,11, 4,25};
  localparam int PC1_T [56] = '{
    57,49,41,33,25,17, 9, 1,58,50,42,34,26,18,10, 2,59,51,43,35,27,19,11, 3,60,52,44,36,
    63,55,47,39,31,23,15, 7,62,54,46,38,30,22,14, 6,61,53,45,37,29,21,13, 5,28,20,12, 4};
  localparam int PC2_T [48] = '{
    14,17,11,24, 1, 5, 3,28,15, 6,21,10,23,19,12, 4,26, 8,16, 7,27,20,13, 2,
    41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  localparam logic [1:0] SHIFT [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  // Each S-box is stored row-major: index = {b1,b6} * 16 + b2..b5.
  localparam logic [3:0] SBOX [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  function automatic logic [0:63] ip_perm(input logic [0:63] x);
    logic [0:63] y;
    for (int i = 0; i < 64; i++) y[6'(i)] = x[6'(IP_T[i] - 1)];
    return y;
  endfunction

  function automatic logic [0:63] fp_perm(input logic [0:63] x);
    logic [0:63] y;
    for (int i = 0; i < 64; i++) y[6'(i)] = x[6'(FP_T[i] - 1)];
    return y;
  endfunction

  function automatic logic [0:47] e_expand(input logic [0:31] x);
    logic [0:47] y;
    for (int i = 0; i < 48; i++) y[6'(i)] = x[5'(E_T[i] - 1)];
    return y;
  endfunction

  function automatic logic [0:31] p_perm(input logic [0:31] x);
    logic [0:31] y;
    for (int i = 0; i < 32; i++) y[5'(i)] = x[5'(P_T[i] - 1)];
    return y;
  endfunction

  function automatic logic [0:55] pc1_perm(input logic [0:63] x);
    logic [0:55] y;
    for (int i = 0; i < 56; i++) y[6'(i)] = x[6'(PC1_T[i] - 1)];
    return y;
  endfunction

  function automatic logic [0:47] pc2_perm(input logic [0:55] x);
    logic [0:47] y;
    for (int i = 0; i < 48; i++) y[6'(i)] = x[6'(PC2_T[i] - 1)];
    return y;
  endfunction

  function automatic logic [0:31] sbox_sub(input logic [0:47] x);
    logic [0:31] y;
    logic [0:5]  b;
    y = '0;
    for (int j = 0; j < 8; j++) begin
      b = x[6'(6 * j) +: 6];
      y[5'(4 * j) +: 4] = SBOX[3'(j)][{b[0], b[5], b[1:4]}];
    end
    return y;
  endfunction

  function automatic logic [0:27] rot28(input logic [0:27] c, input logic [1:0] n,
                                        input logic right);
    case ({right, n})
      3'b001:  return {c[1:27], c[0]};
      3'b010:  return {c[2:27], c[0:1]};
      3'b101:  return {c[27], c[0:26]};
      3'b110:  return {c[26:27], c[0:25]};
      default: return c;
    endcase
  endfunction

  // Decrypt walks the schedule backwards; its first round uses C0/D0 as-is (== K16).
  function automatic logic [1:0] shift_amt(input int r, input logic dec);
    if (!dec) return SHIFT[4'(r)];
    if (r == 0) return 2'd0;
    return SHIFT[4'(16 - r)];
  endfunction

endpackage

// File: rtl/des_iter_engine_if.sv
// Upstream/downstream valid-ready bus of the DES engine; bit 0 of each block is DES bit 1.
interface des_iter_engine_if;
  logic        in_valid;
  logic        in_ready;
  logic        decrypt;
  logic [0:63] plaintext;
  logic [0:63] key;
  logic        out_valid;
  logic        out_ready;
  logic [0:63] cyphertext;

  modport master (output in_valid, decrypt, plaintext, key, out_ready,
                  input  in_ready, out_valid, cyphertext);
  modport slave  (input  in_valid, decrypt, plaintext, key, out_ready,
                  output in_ready, out_valid, cyphertext);
endinterface

// File: rtl/des_iter_engine_round.sv
// One combinational Feistel round together with its key-schedule rotation step.
module des_iter_engine_round
  import des_iter_engine_pkg::*;
(
  input  logic [0:31] l_i,
  input  logic [0:31] r_i,
  input  logic [0:27] c_i,
  input  logic [0:27] d_i,
  input  logic [1:0]  shift_i,
  input  logic        dec_i,
  output logic [0:31] l_o,
  output logic [0:31] r_o,
  output logic [0:27] c_o,
  output logic [0:27] d_o
);
  logic [0:47] subkey;

  assign c_o    = rot28(c_i, shift_i, dec_i);
  assign d_o    = rot28(d_i, shift_i, dec_i);
  assign subkey = pc2_perm({c_o, d_o});
  assign l_o    = r_i;
  assign r_o    = l_i ^ p_perm(sbox_sub(e_expand(r_i) ^ subkey));
endmodule

// File: rtl/des_iter_engine.sv
// Iterative DES engine: ROUNDS_PER_CYCLE unrolled rounds per enabled clock, valid/ready on both sides.
module des_iter_engine
  import des_iter_engine_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input logic          clk,
  input logic          reset,
  input logic          en,
  des_iter_engine_if.slave bus
);
  localparam int N_ITER = 16 / ROUNDS_PER_CYCLE;

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
        ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16)) begin : g_bad_rpc
    $error("des_iter_engine: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        dec_q;
  logic [0:31] l_q, r_q;
  logic [0:27] c_q, d_q;
  logic        out_valid_q;
  logic [0:63] cyph_q;

  logic [0:31] l_ch [ROUNDS_PER_CYCLE+1];
  logic [0:31] r_ch [ROUNDS_PER_CYCLE+1];
  logic [0:27] c_ch [ROUNDS_PER_CYCLE+1];
  logic [0:27] d_ch [ROUNDS_PER_CYCLE+1];
  logic [0:31] l_d, r_d;
  logic [0:27] c_d, d_d;
  logic [0:63] ip_w;
  logic [0:55] pc1_w;
  logic        accept, last;

  assign l_ch[0] = l_q;
  assign r_ch[0] = r_q;
  assign c_ch[0] = c_q;
  assign d_ch[0] = d_q;

  for (genvar k = 0; k < ROUNDS_PER_CYCLE; k++) begin : g_rnd
    des_iter_engine_round u_rnd (
      .l_i     (l_ch[k]),
      .r_i     (r_ch[k]),
      .c_i     (c_ch[k]),
      .d_i     (d_ch[k]),
      .shift_i (shift_amt(int'(cnt_q) * ROUNDS_PER_CYCLE + k, dec_q)),
      .dec_i   (dec_q),
      .l_o     (l_ch[k+1]),
      .r_o     (r_ch[k+1]),
      .c_o     (c_ch[k+1]),
      .d_o     (d_ch[k+1])
    );
  end

  assign l_d = l_ch[ROUNDS_PER_CYCLE];
  assign r_d = r_ch[ROUNDS_PER_CYCLE];
  assign c_d = c_ch[ROUNDS_PER_CYCLE];
  assign d_d = d_ch[ROUNDS_PER_CYCLE];

  assign ip_w  = ip_perm(bus.plaintext);
  assign pc1_w = pc1_perm(bus.key);
  assign last  = (cnt_q == 4'(N_ITER - 1));

  assign bus.in_ready   = (state_q == IDLE) | ((state_q == DONE) & bus.out_ready);
  assign accept         = bus.in_valid & bus.in_ready & en;
  assign bus.out_valid  = out_valid_q;
  assign bus.cyphertext = cyph_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dec_q       <= 1'b0;
      l_q         <= '0;
      r_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      out_valid_q <= 1'b0;
      cyph_q      <= '0;
    end else if (en) begin
      // A DONE->RUN back-to-back accept also retires the pending result here.
      if (accept) begin
        state_q     <= RUN;
        cnt_q       <= '0;
        dec_q       <= bus.decrypt;
        l_q         <= ip_w[0:31];
        r_q         <= ip_w[32:63];
        c_q         <= pc1_w[0:27];
        d_q         <= pc1_w[28:55];
        out_valid_q <= 1'b0;
      end else begin
        case (state_q)
          RUN: begin
            l_q   <= l_d;
            r_q   <= r_d;
            c_q   <= c_d;
            d_q   <= d_d;
            cnt_q <= cnt_q + 4'd1;
            if (last) begin
              cyph_q      <= fp_perm({r_d, l_d});
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end
          DONE: begin
            if (bus.out_ready) begin
              out_valid_q <= 1'b0;
              state_q     <= IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_des_iter_engine.sv
// Directed bench: one engine per ROUNDS_PER_CYCLE value, exercised in turn from a single sequence.
module tb_des_iter_engine;
  localparam logic [63:0] PT1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] K1  = 64'h133457799BBCDFF1;
  localparam logic [63:0] CT1 = 64'h85E813540F0AB405;
  localparam logic [63:0] PT2 = 64'h8787878787878787;
  localparam logic [63:0] K2  = 64'h0E329232EA6D0D73;
  localparam logic [63:0] CT2 = 64'h0000000000000000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b1;
  logic        in_valid = 1'b0;
  logic        decrypt = 1'b0;
  logic        out_ready = 1'b1;
  logic [63:0] plaintext = '0;
  logic [63:0] key = '0;
  int          sel = 0;

  logic        ov [5];
  logic        ir [5];
  logic [63:0] ct [5];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_u
    des_iter_engine_if bus ();
    assign bus.in_valid  = in_valid && (sel == g);
    assign bus.decrypt   = decrypt;
    assign bus.plaintext = plaintext;
    assign bus.key       = key;
    assign bus.out_ready = out_ready;
    assign ov[g] = bus.out_valid;
    assign ir[g] = bus.in_ready;
    assign ct[g] = bus.cyphertext;

    des_iter_engine #(.ROUNDS_PER_CYCLE(1 << g)) dut (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .bus   (bus)
    );
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL rpc=%0d %s observed=%h expected=%h", 1 << sel, tag, obs, exp);
    end
  endtask

  // Called at a negedge: presents one block and returns one negedge after the accept edge.
  task automatic start(input logic [63:0] pt, input logic [63:0] k, input logic d,
                       input logic ordy);
    plaintext = pt;
    key       = k;
    decrypt   = d;
    out_ready = ordy;
    in_valid  = 1'b1;
    en        = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid, with a bound.
  task automatic wait_done(input bit toggle, output int lat);
    lat = 0;
    while (!ov[sel] && lat < 64) begin
      if (toggle) en = (lat % 2 == 1);
      @(negedge clk);
      lat++;
    end
    en = 1'b1;
  endtask

  initial begin
    int          n, lat;
    logic [63:0] held, p, k, c;
    for (int u = 0; u < 5; u++) begin
      sel = u;
      n   = 16 >> u;

      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("reset_in_ready", 64'(ir[sel]), 64'd1);
      check("reset_out_valid", 64'(ov[sel]), 64'd0);
      check("reset_cyphertext", ct[sel], 64'd0);
      reset = 1'b0;
      @(negedge clk);

      start(PT1, K1, 1'b0, 1'b0);
      wait_done(1'b0, lat);
      check("enc1_latency", 64'(lat), 64'(n));
      check("enc1_result", ct[sel], CT1);
      held = ct[sel];
      repeat (5) begin
        @(negedge clk);
        check("bp_stable", ct[sel], held);
        check("bp_in_ready", 64'(ir[sel]), 64'd0);
        check("bp_out_valid", 64'(ov[sel]), 64'd1);
      end
      start(PT2, K2, 1'b0, 1'b1);
      check("bp_release_out_valid", 64'(ov[sel]), 64'd0);
      check("bp_release_keep", ct[sel], CT1);
      wait_done(1'b0, lat);
      check("enc2_latency", 64'(lat), 64'(n));
      check("enc2_result", ct[sel], CT2);

      start(CT1, K1, 1'b1, 1'b1);
      wait_done(1'b0, lat);
      check("dec1_latency", 64'(lat), 64'(n));
      check("dec1_result", ct[sel], PT1);

      start(PT1, K1, 1'b0, 1'b1);
      wait_done(1'b1, lat);
      check("en_toggle_latency", 64'(lat), 64'(2 * n));
      check("en_toggle_result", ct[sel], CT1);

      start(PT2, K2, 1'b0, 1'b1);
      #1 reset = 1'b1;
      #1;
      check("midrun_reset_out_valid", 64'(ov[sel]), 64'd0);
      check("midrun_reset_cyphertext", ct[sel], 64'd0);
      check("midrun_reset_in_ready", 64'(ir[sel]), 64'd1);
      reset = 1'b0;
      @(negedge clk);
      start(PT1, K1, 1'b0, 1'b1);
      wait_done(1'b0, lat);
      check("post_reset_latency", 64'(lat), 64'(n));
      check("post_reset_result", ct[sel], CT1);

      for (int i = 0; i < 100; i++) begin
        p = {$urandom, $urandom};
        k = {$urandom, $urandom};
        start(p, k, 1'b0, 1'b1);
        wait_done(1'b0, lat);
        c = ct[sel];
        start(c, k, 1'b1, 1'b1);
        wait_done(1'b0, lat);
        check("roundtrip", ct[sel], p);
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
